// File: rtl/sd_bmp_slideshow.sv
// BMP slideshow reader: requests each image's sectors from the SD read controller, parses the
// BMP pixel-data offset, and turns 24-bit BGR data into an RGB565/RGB888 pixel write stream.
module sd_bmp_slideshow #(
    parameter int          NUM_PHOTOS      = 4,
    parameter logic [31:0] PHOTO_BASE_ADDR = 32'd8448,
    parameter logic [31:0] PHOTO_STRIDE    = 32'd2816,
    parameter int          DWELL_CYCLES    = 50_000_000,
    parameter int          OUT_RGB565      = 1,
    localparam int         OUT_W           = (OUT_RGB565 != 0) ? 16 : 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      sd_sec_num,
    input  logic [23:0]      pix_max,
    input  logic             rd_busy,
    input  logic             sd_rd_val_en,
    input  logic [15:0]      sd_rd_val_data,
    input  logic             pause,
    input  logic             next_req,
    output logic             rd_start_en,
    output logic [31:0]      rd_sec_addr,
    output logic             pix_wr_en,
    output logic [OUT_W-1:0] pix_wr_data,
    output logic             frame_start,
    output logic [7:0]       photo_idx,
    output logic             hdr_err
);

    localparam logic [1:0] R_START = 2'd0;
    localparam logic [1:0] R_READ  = 2'd1;
    localparam logic [1:0] R_DWELL = 2'd2;

    localparam logic [1:0] P_HDR   = 2'd0;
    localparam logic [1:0] P_PIX   = 2'd1;
    localparam logic [1:0] P_DRAIN = 2'd2;

    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
    localparam logic [7:0]  IDX_LAST   = 8'(NUM_PHOTOS - 1);

    logic [1:0]  rstate;
    logic [1:0]  pstate;
    logic        rd_busy_d0;
    logic        rd_busy_d1;
    logic        neg_busy;
    logic [15:0] sec_cnt;
    logic [31:0] dwell_cnt;
    logic        next_pend;
    logic        bmp_rd_done;

    logic [15:0] wcnt;
    logic [15:0] off_lo;
    logic [15:0] hdr_last;
    logic [1:0]  ph;
    logic [15:0] w0;
    logic [7:0]  b3;
    logic [23:0] pix_cnt;
    logic [31:0] hdr_off;
    logic        hdr_off_bad;
    logic        hdr_bad;
    logic [23:0] pix_rgb;
    logic [OUT_W-1:0] pix_fmt;

    // A completed sector shows up as the falling edge of rd_busy, seen two flops late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_busy_d0 <= 1'b0;
            rd_busy_d1 <= 1'b0;
        end else begin
            rd_busy_d0 <= rd_busy;
            rd_busy_d1 <= rd_busy_d0;
        end
    end

    assign neg_busy = rd_busy_d1 & ~rd_busy_d0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate      <= R_START;
            rd_start_en <= 1'b0;
            rd_sec_addr <= 32'd0;
            sec_cnt     <= 16'd0;
            dwell_cnt   <= 32'd0;
            next_pend   <= 1'b0;
            bmp_rd_done <= 1'b0;
            photo_idx   <= 8'd0;
        end else begin
            rd_start_en <= 1'b0;
            bmp_rd_done <= 1'b0;
            if (next_req && rstate != R_DWELL)
                next_pend <= 1'b1;
            case (rstate)
                R_START: begin
                    rd_start_en <= 1'b1;
                    rd_sec_addr <= PHOTO_BASE_ADDR + 32'(photo_idx) * PHOTO_STRIDE;
                    sec_cnt     <= 16'd0;
                    rstate      <= R_READ;
                end
                R_READ: begin
                    if (neg_busy) begin
                        rd_sec_addr <= rd_sec_addr + 32'd1;
                        sec_cnt     <= sec_cnt + 16'd1;
                        if (sec_cnt == sd_sec_num - 16'd1) begin
                            bmp_rd_done <= 1'b1;
                            rstate      <= R_DWELL;
                        end else begin
                            rd_start_en <= 1'b1;
                        end
                    end
                end
                R_DWELL: begin
                    // A skip requested while reading makes this dwell a single cycle, pause or not.
                    if (next_pend || next_req || (!pause && dwell_cnt == DWELL_LAST)) begin
                        dwell_cnt <= 32'd0;
                        next_pend <= 1'b0;
                        photo_idx <= (photo_idx == IDX_LAST) ? 8'd0 : photo_idx + 8'd1;
                        rstate    <= R_START;
                    end else if (!pause) begin
                        dwell_cnt <= dwell_cnt + 32'd1;
                    end
                end
                default: rstate <= R_START;
            endcase
        end
    end

    assign hdr_off     = {sd_rd_val_data, off_lo};
    assign hdr_off_bad = (hdr_off < 32'd54) || hdr_off[0] || (sd_rd_val_data != 16'd0);
    assign hdr_bad     = (pstate == P_HDR) && sd_rd_val_en && (wcnt == 16'd6) && hdr_off_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hdr_err <= 1'b0;
        else if (rstate == R_START)
            hdr_err <= 1'b0;
        else if (hdr_bad)
            hdr_err <= 1'b1;
    end

    // Byte order within three words is B,G,R,B,G,R; the first pixel completes on the second word.
    always_comb begin
        pix_rgb = {sd_rd_val_data[15:8], sd_rd_val_data[7:0], b3};
        if (ph == 2'd1)
            pix_rgb = {sd_rd_val_data[7:0], w0[15:8], w0[7:0]};
    end

    generate
        if (OUT_W == 16) begin : g_rgb565
            logic unused_low_bits;
            assign unused_low_bits = ^{pix_rgb[18:16], pix_rgb[9:8], pix_rgb[2:0]};
            assign pix_fmt = {pix_rgb[23:19], pix_rgb[15:10], pix_rgb[7:3]};
        end else begin : g_rgb888
            assign pix_fmt = pix_rgb;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate      <= P_HDR;
            wcnt        <= 16'd0;
            off_lo      <= 16'd0;
            hdr_last    <= 16'd0;
            ph          <= 2'd0;
            w0          <= 16'd0;
            b3          <= 8'd0;
            pix_cnt     <= 24'd0;
            pix_wr_en   <= 1'b0;
            pix_wr_data <= '0;
            frame_start <= 1'b0;
        end else begin
            pix_wr_en   <= 1'b0;
            frame_start <= 1'b0;
            case (pstate)
                P_HDR: begin
                    if (sd_rd_val_en) begin
                        wcnt <= wcnt + 16'd1;
                        if (wcnt == 16'd5) begin
                            off_lo <= sd_rd_val_data;
                        end else if (wcnt == 16'd6) begin
                            if (hdr_off_bad)
                                pstate <= P_DRAIN;
                            else
                                hdr_last <= {1'b0, off_lo[15:1]} - 16'd1;
                        end else if (wcnt > 16'd6 && wcnt == hdr_last) begin
                            pstate <= P_PIX;
                            ph     <= 2'd0;
                        end
                    end
                end
                P_PIX: begin
                    if (sd_rd_val_en) begin
                        case (ph)
                            2'd0: begin
                                w0 <= sd_rd_val_data;
                                ph <= 2'd1;
                            end
                            2'd1: begin
                                b3 <= sd_rd_val_data[15:8];
                                ph <= 2'd2;
                            end
                            default: ph <= 2'd0;
                        endcase
                        if (ph != 2'd0) begin
                            pix_wr_en   <= 1'b1;
                            pix_wr_data <= pix_fmt;
                            frame_start <= (pix_cnt == 24'd0);
                            pix_cnt     <= pix_cnt + 24'd1;
                            if (pix_cnt + 24'd1 == pix_max) begin
                                pstate <= P_DRAIN;
                                ph     <= 2'd0;
                            end
                        end
                    end
                end
                P_DRAIN: ;
                default: pstate <= P_DRAIN;
            endcase
            // End of file wins over anything above, including a short file still in HDR/PIX.
            if (bmp_rd_done) begin
                pstate  <= P_HDR;
                wcnt    <= 16'd0;
                pix_cnt <= 24'd0;
                ph      <= 2'd0;
            end
        end
    end

endmodule
